// File: rtl/anim_pkg.sv
// Shared animation encodings and widths used by the scheduler, the
// animation memories and the display mux.
package anim_pkg;

    localparam int unsigned ANIM_W = 2;
    localparam int unsigned STEP_W = 4;

    typedef enum logic [ANIM_W-1:0] {
        AnimIdle  = 2'd0,
        AnimSleep = 2'd1,
        AnimEat   = 2'd2,
        AnimPlay  = 2'd3
    } anim_t;

    typedef enum logic [1:0] {
        StIdle,
        StSleep,
        StOneshot
    } sched_state_t;

    // Animation shown while the scheduler sits in a given state.
    function automatic anim_t state_anim(sched_state_t st, anim_t latched);
        anim_t a;
        case (st)
            StSleep:   a = AnimSleep;
            StOneshot: a = latched;
            default:   a = AnimIdle;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/frame_timer.sv
// Frame divider: counts clk cycles per animation frame and flags the last
// cycle of each frame. A synchronous clear restarts the frame.
module frame_timer #(
    parameter int unsigned FRAME_DIV = 33_554_432
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    output logic tick_o
);

    localparam int unsigned CntW = $clog2(FRAME_DIV);
    localparam logic [CntW-1:0] LastCnt = CntW'(FRAME_DIV - 1);

    logic [CntW-1:0] div_cnt_q, div_cnt_d;

    assign tick_o = (div_cnt_q == LastCnt);

    always_comb begin
        div_cnt_d = div_cnt_q + CntW'(1);
        if (clr_i || tick_o) begin
            div_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: rtl/anim_scheduler.sv
// Chooses the displayed animation (idle, sleep, or a one-shot request) and
// drives one shared, restartable frame step sequence for the sprite memories.
module anim_scheduler #(
    parameter int unsigned FRAME_DIV     = 33_554_432,
    parameter int unsigned NUM_STEPS     = 16,
    parameter int unsigned ONESHOT_LOOPS = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       req_valid_i,
    input  logic [1:0] req_anim_i,
    output logic       req_ready_o,
    input  logic       stat_sleep_i,
    output logic [1:0] anim_sel_o,
    output logic [3:0] frame_step_o,
    output logic       frame_tick_o,
    output logic       anim_done_o,
    output logic       busy_o
);

    import anim_pkg::*;

    localparam int unsigned LoopW = (ONESHOT_LOOPS > 1) ? $clog2(ONESHOT_LOOPS) : 1;
    localparam logic [STEP_W-1:0] LastStep = STEP_W'(NUM_STEPS - 1);
    localparam logic [LoopW-1:0]  LastLoop = LoopW'(ONESHOT_LOOPS - 1);

    sched_state_t      state_q, state_d;
    anim_t             latch_q, latch_d;
    anim_t             anim_q, anim_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [LoopW-1:0]  loop_q, loop_d;
    logic              tick_q, tick_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              tick, wrap, restart;

    frame_timer #(
        .FRAME_DIV(FRAME_DIV)
    ) u_frame_timer (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .clr_i (restart),
        .tick_o(tick)
    );

    assign wrap        = tick && (step_q == LastStep);
    assign req_ready_o = (state_q == StIdle) && !stat_sleep_i;

    always_comb begin
        state_d = state_q;
        latch_d = latch_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Sleep outranks requests; an IDLE request is accepted but ignored.
                if (stat_sleep_i) begin
                    state_d = StSleep;
                end else if (req_valid_i && (req_anim_i != AnimIdle)) begin
                    state_d = StOneshot;
                    latch_d = anim_t'(req_anim_i);
                end
            end
            StSleep: begin
                if (wrap && !stat_sleep_i) begin
                    state_d = StIdle;
                end
            end
            StOneshot: begin
                if (wrap && (loop_q == LastLoop)) begin
                    done_d  = 1'b1;
                    state_d = stat_sleep_i ? StSleep : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        restart = (state_d != state_q);

        step_d = step_q;
        loop_d = loop_q;
        if (restart) begin
            step_d = '0;
            loop_d = '0;
        end else if (tick) begin
            step_d = wrap ? '0 : step_q + STEP_W'(1);
            if (wrap && (state_q == StOneshot)) begin
                loop_d = loop_q + LoopW'(1);
            end
        end

        tick_d = restart || tick;
        anim_d = state_anim(state_d, latch_d);
        busy_d = (state_d == StOneshot);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            latch_q <= AnimIdle;
            anim_q  <= AnimIdle;
            step_q  <= '0;
            loop_q  <= '0;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            latch_q <= latch_d;
            anim_q  <= anim_d;
            step_q  <= step_d;
            loop_q  <= loop_d;
            tick_q  <= tick_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign anim_sel_o   = anim_q;
    assign frame_step_o = step_q;
    assign frame_tick_o = tick_q;
    assign anim_done_o  = done_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_anim_scheduler.sv
// Randomized bench for anim_scheduler: a time-since-restart reference model
// predicts every frame/done event into a queue that a monitor drains.
module tb_anim_scheduler;

    localparam int FD = 4;
    localparam int NS = 4;
    localparam int NL = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic [1:0] req_anim = 2'd0;
    logic       stat_sleep = 1'b0;
    logic       req_ready;
    logic [1:0] anim_sel;
    logic [3:0] frame_step;
    logic       frame_tick, anim_done, busy;

    anim_scheduler #(
        .FRAME_DIV    (FD),
        .NUM_STEPS    (NS),
        .ONESHOT_LOOPS(NL)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_anim_i  (req_anim),
        .req_ready_o (req_ready),
        .stat_sleep_i(stat_sleep),
        .anim_sel_o  (anim_sel),
        .frame_step_o(frame_step),
        .frame_tick_o(frame_tick),
        .anim_done_o (anim_done),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       tick;
        logic       done;
        logic [1:0] anim;
        logic [3:0] step;
        logic       busy;
    } evt_t;

    evt_t exp_q[$];
    int   n_tests = 0;
    int   n_fail = 0;

    // Model: mode 0 idle, 1 sleep, 2 one-shot; m_t = cycles since last restart.
    int   m_mode = 0;
    int   m_anim = 0;
    int   m_t = 0;
    bit   m_accept = 0;
    int   cyc = 0;
    int   acc_cyc = 0;

    function automatic void check(string name, int act, int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            m_accept = 0;
            if (rst_n) begin
                bit   restart;
                bit   boundary;
                bit   done;
                int   nf;
                evt_t e;
                restart  = 0;
                done     = 0;
                boundary = ((m_t + 1) % FD) == 0;
                nf       = (m_t + 1) / FD;
                case (m_mode)
                    0: begin
                        if (stat_sleep) begin
                            m_mode  = 1;
                            restart = 1;
                        end else if (req_valid) begin
                            m_accept = 1;
                            if (req_anim != 2'd0) begin
                                m_mode  = 2;
                                m_anim  = int'(req_anim);
                                restart = 1;
                                acc_cyc = cyc;
                            end
                        end
                    end
                    1: begin
                        if (boundary && (nf % NS) == 0 && !stat_sleep) begin
                            m_mode  = 0;
                            restart = 1;
                        end
                    end
                    default: begin
                        if (boundary && nf == NL * NS) begin
                            done    = 1;
                            m_mode  = stat_sleep ? 1 : 0;
                            restart = 1;
                        end
                    end
                endcase
                m_t = restart ? 0 : m_t + 1;
                if (restart || boundary) begin
                    e.tick = 1'b1;
                    e.done = done;
                    e.anim = (m_mode == 2) ? 2'(m_anim) : 2'(m_mode);
                    e.step = 4'((m_t / FD) % NS);
                    e.busy = (m_mode == 2);
                    exp_q.push_back(e);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                evt_t got;
                got = {frame_tick, anim_done, anim_sel, frame_step, busy};
                check("req_ready", int'(req_ready), int'(m_mode == 0 && !stat_sleep));
                if (frame_tick || anim_done || exp_q.size() > 0) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_event", int'(got), 0);
                    end else begin
                        evt_t e;
                        e = exp_q.pop_front();
                        check("event{tick,done,anim,step,busy}", int'(got), int'(e));
                    end
                end
                if (anim_done) begin
                    check("oneshot_duration", cyc - acc_cyc, NL * NS * FD);
                end
            end
        end
    end

    task automatic step_cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send_req(input int anim);
        bit ok;
        ok        = 0;
        req_valid = 1'b1;
        req_anim  = 2'(anim);
        for (int i = 0; i < 300; i++) begin
            step_cyc(1);
            if (m_accept) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("req_accept_timeout", 0, 1);
        req_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_anim_sel"}, int'(anim_sel), 0);
        check({tag, "_frame_step"}, int'(frame_step), 0);
        check({tag, "_frame_tick"}, int'(frame_tick), 0);
        check({tag, "_anim_done"}, int'(anim_done), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_req_ready"}, int'(req_ready), int'(!stat_sleep));
    endtask

    initial begin
        #1;
        check_reset_outputs("reset");
        step_cyc(2);
        rst_n = 1'b1;

        // Idle stepping, then an EAT one-shot.
        step_cyc(20);
        send_req(2);
        step_cyc(40);

        // Sleep entry, release mid-loop.
        stat_sleep = 1'b1;
        step_cyc(6);
        stat_sleep = 1'b0;
        step_cyc(20);

        // Sleep raised during PLAY.
        send_req(3);
        step_cyc(5);
        stat_sleep = 1'b1;
        step_cyc(30);
        stat_sleep = 1'b0;
        step_cyc(20);

        // No-op request.
        send_req(0);
        step_cyc(10);

        for (int k = 0; k < 300; k++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 2) begin
                stat_sleep = 1'b1;
                step_cyc(int'($urandom_range(1, 20)));
                stat_sleep = 1'b0;
            end else if (r < 6) begin
                send_req(int'($urandom_range(0, 3)));
            end else begin
                step_cyc(int'($urandom_range(1, 10)));
            end
        end
        step_cyc(40);

        // Asynchronous reset in the middle of a one-shot.
        send_req(3);
        step_cyc(10);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        m_mode = 0;
        m_t    = 0;
        #1;
        check_reset_outputs("midreset");
        step_cyc(3);
        rst_n = 1'b1;
        step_cyc(25);

        @(negedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/anim_scheduler.md
# anim_scheduler

Sequences the pet's sprite animations for the display path. It decides which animation ROM is shown (idle, sleep, eat, play) and generates the frame step index that the per-animation memories consume. Two requesters share the single animation output: game logic issues one-shot requests through a valid/ready handshake, and the status logic drives a sleep level that has priority. The block replaces the free-running per-animation step counters with one shared, restartable frame sequencer.

## Interface
- FRAME_DIV, 33_554_432: clk cycles per animation frame; ≥2.
- NUM_STEPS, 16: frames per animation loop; 2..16.
- ONESHOT_LOOPS, 2: full loops played per accepted one-shot request; ≥1.
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  1  game-logic request strobe; held until accepted.
- req_anim  in  2  requested animation: 0 IDLE, 1 SLEEP, 2 EAT, 3 PLAY.
- req_ready  out  1  request accepted when req_valid && req_ready.
- stat_sleep  in  1  status-driven sleep level, priority requester.
- anim_sel  out  2  animation currently displayed (same encoding as req_anim).
- frame_step  out  4  frame index into selected animation memory.
- frame_tick  out  1  one-cycle pulse on the first cycle of each new frame_step value.
- anim_done  out  1  one-cycle pulse when a one-shot finishes.
- busy  out  1  high while a one-shot is playing.

## Operation
- States: S_IDLE (anim_sel 0, loops forever), S_SLEEP (anim_sel 1, loops), S_ONESHOT (anim_sel = latched request, plays ONESHOT_LOOPS loops).
- Frame timer: div_cnt counts 0..FRAME_DIV-1. Tick when div_cnt == FRAME_DIV-1. On tick, frame_step increments and wraps NUM_STEPS-1 → 0. Counting is unsigned. div_cnt width is $clog2(FRAME_DIV).
- Restart: every state change clears div_cnt, frame_step and loop_cnt on the transition edge. frame_tick also pulses then.
- req_ready = (state == S_IDLE) && !stat_sleep. This is combinational from registered state.
- S_IDLE + stat_sleep high → S_SLEEP. Takes priority over any pending request.
- S_IDLE + accepted request: req_anim 1/2/3 → S_ONESHOT with that code latched. req_anim 0 is accepted as a no-op; state and step continue undisturbed.
- S_ONESHOT: loop_cnt increments on each frame_step wrap. On the wrap where loop_cnt == ONESHOT_LOOPS-1, the block pulses anim_done and goes to S_SLEEP if stat_sleep is high, else S_IDLE. It is not preemptible.
- S_SLEEP: exits to S_IDLE only on a tick that wraps frame_step to 0 while stat_sleep is low, so a loop is never truncated. stat_sleep toggling mid-loop has no effect until the wrap.
- busy = (state == S_ONESHOT).
- Reset values: state S_IDLE, anim_sel 0, frame_step 0, frame_tick 0, anim_done 0, busy 0, div_cnt 0, loop_cnt 0. req_ready follows !stat_sleep.

## Timing
- All outputs except req_ready are registered.
- Accept on edge N → anim_sel, busy and frame_step 0 are valid from edge N+1, with frame_tick high for that cycle.
- First advance after a restart occurs FRAME_DIV cycles later.
- One-shot duration is ONESHOT_LOOPS·NUM_STEPS·FRAME_DIV cycles from accept to the anim_done pulse. anim_done and the new anim_sel appear in the same cycle.
- Reset is asynchronous. Asserting it mid-one-shot clears outputs immediately, with no anim_done.

## Structure
- Shared package anim_pkg holds:
  - anim_t encoding (IDLE/SLEEP/EAT/PLAY);
  - scheduler state enum;
  - ANIM_W = 2 and STEP_W = 4 constants, reused by the animation memories and the display mux.
- One sub-module: frame_timer (div_cnt plus tick output, synchronous clear input, parameter FRAME_DIV). The FSM and the step and loop counters stay in anim_scheduler.

## Test plan
All scenarios use FRAME_DIV=4, NUM_STEPS=4, ONESHOT_LOOPS=2.
- **Idle after reset:** release rst with stat_sleep 0 → anim_sel 0; frame_step sequence 0,1,2,3,0 advancing every 4 cycles with frame_tick on each change; req_ready 1.
- **EAT one-shot:** req_valid with req_anim 2 accepted at edge N → anim_sel 2, busy 1, frame_step 0 at N+1. anim_done pulses at N+32 with anim_sel 0 and busy 0.
- **Sleep entry and exit:** stat_sleep 1 in idle → anim_sel 1 next cycle, req_ready 0. Drop stat_sleep at frame_step 1 → stays asleep through step 3, returns to idle on the next wrap.
- **Sleep during one-shot:** raise stat_sleep while PLAY is active → PLAY completes all 32 cycles. anim_done and anim_sel 1 appear together.
- **Reset mid-operation and no-op request:** assert rst during a one-shot → all outputs reset asynchronously, no anim_done. A request with req_anim 0 in idle is accepted without disturbing the frame_step cadence.
